muldiv_seq: RTL
===============

# muldiv_seq

Sequencer for RV32M arithmetic in the execute stage. Accepts one M-extension operation at a time and stalls the pipeline while it runs. MUL/MULH/MULHSU/MULHU go to the shared fixed-latency external multiplier; DIV/DIVU/REM/REMU go to an internal iterative divider. Returns a single-cycle result beat with rd write information.

## Interface
- `MULT_LATENCY`, default 3: cycles from `mult_start_o` to valid `mult_result_i`; legal range 1..15.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; active-low, synchronous.
- `start_i`  in  1  EX holds an M-extension R-type op (funct7[0]=1).
- `funct3_i`  in  3  M-op select, using the F3_MUL..F3_REMU codes.
- `rs1_data_i`, `rs2_data_i`  in  32 each  operands.
- `rd_addr_i`  in  5  destination register.
- `flush_i`  in  1  abort any operation in flight.
- `stall_o`  out  1  holds IF/ID/EX.
- `mult_start_o`  out  1  one-cycle multiplier launch.
- `mult_type_o`  out  2  MULT_TYPE_LOW32, SxS_HIGH32, SxU_HIGH32 or UxU_HIGH32.
- `mult_a_o`, `mult_b_o`  out  32 each  multiplier operands.
- `mult_result_i`  in  32  multiplier result.
- `done_o`  out  1  result beat.
- `rd_we_o`  out  1  register write enable; equals `done_o`.
- `rd_addr_o`  out  5  destination register.
- `rd_data_o`  out  32  result data.

## Operation
- States:
  - IDLE
  - MUL_WAIT
  - DIV_RUN
  - DIV_FIX
  - DONE
- IDLE with `start_i`=1 (accept, call it cycle 0):
  - Latch funct3, operands and rd_addr.
  - Mul op: drive `mult_start_o`=1, type and operands combinationally in cycle 0; load counter with MULT_LATENCY; go to MUL_WAIT.
  - Div op, rs2=0: quotient = 0xFFFFFFFF, remainder = rs1; go to DONE.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient = 0x80000000, remainder = 0; go to DONE.
  - Other div ops: load |rs1| and |rs2| (absolute value only for signed ops) into the divider; go to DIV_RUN.
- MUL_WAIT: counter decrements each cycle. `mult_result_i` is sampled in cycle MULT_LATENCY, then go to DONE.
- DIV_RUN: one restoring shift-subtract step per cycle, 32 cycles, then go to DIV_FIX.
- DIV_FIX sign correction:
  - Quotient is negated if the operand signs differ (DIV only).
  - Remainder takes the sign of rs1 (REM only).
  - Go to DONE.
- DONE: `done_o`=`rd_we_o`=1 with the registered result; `start_i` is ignored (it is the same held instruction); next state is IDLE.
- `flush_i`=1 in any state:
  - Next state is IDLE.
  - No `done_o` is produced.
  - `stall_o`=0 in that cycle.
  - A multiplier result still in flight is discarded.
- All arithmetic is 32-bit modulo. The divider holds a 33-bit partial remainder internally.

## Timing
- Reset values: every output and all state registers are 0; state = IDLE.
- `stall_o` = (IDLE & `start_i`) | MUL_WAIT | DIV_RUN | DIV_FIX, forced to 0 by `flush_i`. It is low in DONE, so the instruction advances with the result.
- Latency, accept cycle to `done_o`:
  - Mul: MULT_LATENCY+1 cycles.
  - Normal div: 34 cycles.
  - Divide by zero or overflow: 1 cycle.
- `done_o` is always a single cycle. A new op can be accepted the cycle after DONE at the earliest.
- Reset asserted mid-operation: IDLE and zero outputs on the next edge.

## Structure
- Shared header (defines.vh) holds the F3_* codes, MULT_TYPE_* codes and the state encoding.
- The iterative unsigned divider is a sub-module `div_iter`: load, step and count, with a 32-bit quotient and remainder.
- The sign handling and the FSM live in `muldiv_seq`.

## Test plan
- MUL 7 × 0xFFFFFFFD with a MULT_LATENCY=3 model -> `mult_start_o` and LOW32 in cycle 0; `done_o` in cycle 4 with rd_data 0xFFFFFFEB; stall high in cycles 0-3.
- DIV 0xFFFFFFEC / 3 -> `done_o` in cycle 34 with data 0xFFFFFFFA. REM with the same operands -> 0xFFFFFFFE. REMU 20 / 3 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF in cycle 1. REM 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- Check the DONE beat and back-to-back issue:
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - `start_i` held high through DONE -> exactly one `done_o`.
  - A new op issued the next cycle is accepted.
- `flush_i` in cycle 10 of a DIV -> IDLE in cycle 11, no `done_o`, `stall_o` 0 in cycle 10.
- `rst`=0 during DIV_RUN -> all outputs 0 on the next edge; a subsequent DIVU 100 / 7 -> 14.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the RV32M sequencer.
// Holds the funct3 codes for M-extension ops, the multiplier type codes,
// the FSM state encoding, and small decode helpers used by muldiv_seq.
package muldiv_seq_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] MULT_TYPE_LOW32      = 2'd0;
  localparam logic [1:0] MULT_TYPE_SXS_HIGH32 = 2'd1;
  localparam logic [1:0] MULT_TYPE_SXU_HIGH32 = 2'd2;
  localparam logic [1:0] MULT_TYPE_UXU_HIGH32 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL_WAIT = 3'd1,
    ST_DIV_RUN  = 3'd2,
    ST_DIV_FIX  = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  function automatic logic [1:0] mult_type_of(input logic [2:0] f3);
    case (f3)
      F3_MULH:   return MULT_TYPE_SXS_HIGH32;
      F3_MULHSU: return MULT_TYPE_SXU_HIGH32;
      F3_MULHU:  return MULT_TYPE_UXU_HIGH32;
      default:   return MULT_TYPE_LOW32;
    endcase
  endfunction

  function automatic logic is_mul_op(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_MULHU);
  endfunction

  function automatic logic is_signed_div(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Bus between the execute stage / external multiplier and muldiv_seq.
// slave modport: the sequencer (op request in, stall/multiplier/result out).
// master modport: the surrounding pipeline and multiplier.
interface muldiv_seq_if;
  import muldiv_seq_pkg::*;

  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        stall_o;
  logic        mult_start_o;
  logic [1:0]  mult_type_o;
  logic [31:0] mult_a_o;
  logic [31:0] mult_b_o;
  logic [31:0] mult_result_i;
  logic        done_o;
  logic        rd_we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  modport slave (
    input  start_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i, mult_result_i,
    output stall_o, mult_start_o, mult_type_o, mult_a_o, mult_b_o,
           done_o, rd_we_o, rd_addr_o, rd_data_o
  );

  modport master (
    output start_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i, mult_result_i,
    input  stall_o, mult_start_o, mult_type_o, mult_a_o, mult_b_o,
           done_o, rd_we_o, rd_addr_o, rd_data_o
  );
endinterface

// File: rtl/muldiv_seq_div_iter.sv
// div_iter: unsigned restoring divider, one quotient bit per step.
// Ports: clk, rst (active-low sync), load (capture operands, clear count),
// step (one shift-subtract), dividend_i/divisor_i, quotient_o/remainder_o,
// last_o (high on the step that produces the final quotient bit).
module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        last_o
);
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [4:0]  cnt;
  logic [32:0] shifted;
  logic [32:0] diff;

  // Partial remainder is 33 bits only transiently: after a step it is always
  // below the divisor, so 32 bits of storage suffice.
  assign shifted = {rem, quo[31]};
  assign diff    = shifted - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= dividend_i;
      dvs <= divisor_i;
      cnt <= '0;
    end else if (step) begin
      rem <= diff[32] ? shifted[31:0] : diff[31:0];
      quo <= {quo[30:0], ~diff[32]};
      cnt <= cnt + 5'd1;
    end
  end

  assign quotient_o  = quo;
  assign remainder_o = rem;
  assign last_o      = step && (cnt == 5'd31);
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: RV32M sequencer for the execute stage.
// Ports: clk, rst (active-low sync), bus (muldiv_seq_if.slave) carrying the
// op request, flush, stall, multiplier launch/result and the rd write beat.
// Multiplies run on the external fixed-latency multiplier; divides run on
// div_iter with sign handling done here.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int MULT_LATENCY = 3
) (
  input logic         clk,
  input logic         rst,
  muldiv_seq_if.slave bus
);
  state_t      state;
  logic [3:0]  cnt;
  logic        is_rem_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic        done_q;
  logic [4:0]  rd_q;
  logic [31:0] data_q;

  logic        accept;
  logic        mul_go;
  logic        sgn;
  logic        div_zero;
  logic        div_ovf;
  logic        div_load;
  logic        div_step;
  logic        div_last;
  logic signed [31:0] rs1_s;
  logic signed [31:0] rs2_s;
  logic [31:0] dvd_abs;
  logic [31:0] dvs_abs;
  logic [31:0] quo;
  logic [31:0] rem;

  function automatic logic [31:0] cond_neg(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

  assign rs1_s    = signed'(bus.rs1_data_i);
  assign rs2_s    = signed'(bus.rs2_data_i);
  assign accept   = rst && (state == ST_IDLE) && bus.start_i && !bus.flush_i;
  assign mul_go   = accept && is_mul_op(bus.funct3_i);
  assign sgn      = is_signed_div(bus.funct3_i);
  assign div_zero = (bus.rs2_data_i == 32'd0);
  assign div_ovf  = sgn && (bus.rs1_data_i == 32'h8000_0000) && (bus.rs2_data_i == 32'hFFFF_FFFF);
  assign dvd_abs  = cond_neg(sgn && (rs1_s < 0), bus.rs1_data_i);
  assign dvs_abs  = cond_neg(sgn && (rs2_s < 0), bus.rs2_data_i);
  assign div_load = accept && !is_mul_op(bus.funct3_i) && !div_zero && !div_ovf;
  assign div_step = (state == ST_DIV_RUN) && !bus.flush_i;

  div_iter u_div (
    .clk         (clk),
    .rst         (rst),
    .load        (div_load),
    .step        (div_step),
    .dividend_i  (dvd_abs),
    .divisor_i   (dvs_abs),
    .quotient_o  (quo),
    .remainder_o (rem),
    .last_o      (div_last)
  );

  // The multiplier launch is combinational in the accept cycle so the
  // external unit starts without an extra cycle of latency.
  assign bus.mult_start_o = mul_go;
  assign bus.mult_type_o  = mul_go ? mult_type_of(bus.funct3_i) : 2'd0;
  assign bus.mult_a_o     = mul_go ? bus.rs1_data_i : 32'd0;
  assign bus.mult_b_o     = mul_go ? bus.rs2_data_i : 32'd0;

  assign bus.stall_o = rst && !bus.flush_i &&
                       (((state == ST_IDLE) && bus.start_i) ||
                        (state == ST_MUL_WAIT) || (state == ST_DIV_RUN) ||
                        (state == ST_DIV_FIX));

  assign bus.done_o    = done_q;
  assign bus.rd_we_o   = done_q;
  assign bus.rd_addr_o = rd_q;
  assign bus.rd_data_o = data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush_i) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start_i) begin
              rd_q     <= bus.rd_addr_i;
              is_rem_q <= is_rem_op(bus.funct3_i);
              if (is_mul_op(bus.funct3_i)) begin
                cnt   <= 4'(MULT_LATENCY);
                state <= ST_MUL_WAIT;
              end else if (div_zero) begin
                data_q <= is_rem_op(bus.funct3_i) ? bus.rs1_data_i : 32'hFFFF_FFFF;
                done_q <= 1'b1;
                state  <= ST_DONE;
              end else if (div_ovf) begin
                data_q <= is_rem_op(bus.funct3_i) ? 32'd0 : 32'h8000_0000;
                done_q <= 1'b1;
                state  <= ST_DONE;
              end else begin
                neg_quo_q <= sgn && (rs1_s[31] ^ rs2_s[31]);
                neg_rem_q <= sgn && rs1_s[31];
                state     <= ST_DIV_RUN;
              end
            end
          end
          // Counter reaches 1 in cycle MULT_LATENCY after launch.
          ST_MUL_WAIT: begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              data_q <= bus.mult_result_i;
              done_q <= 1'b1;
              state  <= ST_DONE;
            end
          end
          ST_DIV_RUN: begin
            if (div_last) state <= ST_DIV_FIX;
          end
          ST_DIV_FIX: begin
            data_q <= is_rem_q ? cond_neg(neg_rem_q, rem) : cond_neg(neg_quo_q, quo);
            done_q <= 1'b1;
            state  <= ST_DONE;
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
